// File: rtl/im_pkg.sv
// im_pkg: shared IM geometry, loader state encoding and erased-byte value
package im_pkg;
  localparam int IM_ADDR_W = 8;
  localparam int IM_DATA_W = 8;
  localparam int IM_BYTE_DEPTH = 256;
  localparam logic [IM_DATA_W-1:0] IM_ERASED_BYTE = 8'hFF;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, RUN} ld_state_t;
endpackage

// File: rtl/im_loader_csum.sv
// im_loader_csum: clearable mod-256 byte accumulator with equality compare
//   clr   : zero the running sum
//   add   : add din into the sum this cycle
//   cmp   : byte to compare with the current sum
//   match : sum equals cmp
module im_loader_csum
  import im_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add,
  input  logic [IM_DATA_W-1:0] din,
  input  logic [IM_DATA_W-1:0] cmp,
  output logic                 match
);
  logic [IM_DATA_W-1:0] sum_q, sum_d;
  always_comb sum_d = clr ? '0 : add ? sum_q + din : sum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  assign match = sum_q == cmp;
endmodule

// File: rtl/im_loader.sv
// im_loader: length-prefixed stream loader for the 256-byte IM, shares the IM address port with the CPU PC
//   start/in_valid/in_data/in_ready : load trigger and byte stream (valid/ready)
//   cpu_pc                          : CPU fetch address, drives im_addr outside DATA
//   im_inCmd/im_addr/im_data        : IM write port (zero-latency write on the accept edge)
//   cpu_run/busy/loaded_len/err     : status
//   IM_LOADER_CHECKSUM_EN           : adds a trailing checksum byte and the CHK state
module im_loader
  import im_pkg::*;
#(
  parameter int IM_BYTE_DEPTH = 256,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic [IM_ADDR_W-1:0] cpu_pc,
  output logic                 im_inCmd,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0]    im_data,
  output logic                 cpu_run,
  output logic                 busy,
  output logic [8:0]           loaded_len,
  output logic                 err
);
  ld_state_t state_q, state_d;
  logic [IM_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [8:0] len_q, len_d, loaded_len_q, loaded_len_d;
  logic cpu_run_q;
  logic acc, last, in_data_phase;
  assign in_data_phase = state_q == DATA;
  assign in_ready = state_q == LEN || state_q == DATA || state_q == CHK;
  assign busy = in_ready;
  assign acc = in_valid & in_ready;
  // wr_ptr counts bytes already written, so the accepted byte is number wr_ptr+1
  assign last = ({1'b0, wr_ptr_q} + 9'd1) == len_q;
  assign im_inCmd = in_data_phase & in_valid;
  assign im_addr = in_data_phase ? wr_ptr_q : cpu_pc;
  assign im_data = in_data_phase ? in_data : '0;
  assign cpu_run = cpu_run_q;
  assign loaded_len = loaded_len_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic err_q, err_d, match;
  assign err = err_q;
  im_loader_csum u_csum (
    .clk(clk),
    .rst(rst),
    .clr(state_q == LEN),
    .add(in_data_phase & acc),
    .din(in_data),
    .cmp(in_data),
    .match(match)
  );
`else
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d = len_q;
    loaded_len_d = loaded_len_q;
`ifdef IM_LOADER_CHECKSUM_EN
    err_d = err_q;
`endif
    case (state_q)
      IDLE, RUN: if (start) begin
        state_d = LEN;
`ifdef IM_LOADER_CHECKSUM_EN
        err_d = 1'b0;
`endif
      end
      LEN: if (acc) begin
        len_d = in_data == '0 ? 9'(IM_BYTE_DEPTH) : 9'(in_data);
        wr_ptr_d = '0;
        state_d = DATA;
      end
      DATA: if (acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (last) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = RUN;
          loaded_len_d = len_q;
`endif
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: if (acc) begin
        state_d = match ? RUN : IDLE;
        loaded_len_d = match ? len_q : loaded_len_q;
        err_d = !match;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      len_q <= '0;
      loaded_len_q <= '0;
      cpu_run_q <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q <= len_d;
      loaded_len_q <= loaded_len_d;
      cpu_run_q <= state_d == RUN;
`ifdef IM_LOADER_CHECKSUM_EN
      err_q <= err_d;
`endif
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized self-checking bench for im_loader against a byte-level load model
module tb_im_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0, cpu_pc = 0;
  logic in_ready, im_inCmd, cpu_run, busy, err;
  logic [7:0] im_addr, im_data;
  logic [8:0] loaded_len;
  int n_chk = 0, n_err = 0, gap = 0;
  logic [7:0] mem[256], exp_mem[256];
  logic [7:0] csum_m;
  logic [15:0] wlog[$], exp_wr[$];
  logic [7:0] d[$];
  im_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_pc(cpu_pc), .im_inCmd(im_inCmd), .im_addr(im_addr),
    .im_data(im_data), .cpu_run(cpu_run), .busy(busy), .loaded_len(loaded_len), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) if (im_inCmd) mem[im_addr] = im_data;
  always @(negedge clk) if (im_inCmd) begin
    wlog.push_back({im_addr, im_data});
    check("wr_on_accept", {31'd0, in_valid & in_ready}, 1);
  end
  function automatic logic [15:0] im_read(input logic [7:0] pc);
    return im_inCmd ? 16'hFFFF : {mem[pc], mem[8'(pc + 1)]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (gap > 0) repeat ($urandom_range(0, gap)) begin
      in_valid = 0;
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic send_data(input int i, input logic [7:0] b);
    send_byte(b);
    exp_wr.push_back({8'(i), b});
    exp_mem[i] = b;
    csum_m = csum_m + b;
  endtask
  task automatic do_load(input int n);
    pulse_start();
    csum_m = 0;
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_data(i, d[i]);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(csum_m);
`endif
  endtask
  task automatic check_log(input string tag);
    int m;
    check({tag, "_nwr"}, wlog.size(), exp_wr.size());
    m = wlog.size() < exp_wr.size() ? wlog.size() : exp_wr.size();
    for (int i = 0; i < m; i++) check(tag, {16'd0, wlog[i]}, {16'd0, exp_wr[i]});
    wlog.delete();
    exp_wr.delete();
  endtask
  task automatic rand_data(input int n);
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
  endtask
  initial begin
    int bad;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'hFF;
      exp_mem[i] = 8'hFF;
    end
    cpu_pc = 8'($urandom);
    #2;
    check("rst_cpu_run", {31'd0, cpu_run}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_len", {23'd0, loaded_len}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_ready", {31'd0, in_ready}, 0);
    check("rst_incmd", {31'd0, im_inCmd}, 0);
    check("rst_addr", {24'd0, im_addr}, {24'd0, cpu_pc});
    tick();
    tick();
    rst = 0;
    in_valid = 1;
    in_data = 8'h55;
    tick();
    check("idle_no_accept", wlog.size(), 0);
    in_valid = 0;
    d = '{8'hA1, 8'hB2, 8'hC3};
    do_load(3);
    check("t1_cpu_run", {31'd0, cpu_run}, 1);
    check("t1_len", {23'd0, loaded_len}, 3);
    check("t1_busy", {31'd0, busy}, 0);
    check_log("t1_wr");
    cpu_pc = 0;
    #1 check("t1_read", {16'd0, im_read(0)}, 32'hA1B2);
    pulse_start();
    check("t2_run_drop", {31'd0, cpu_run}, 0);
    check("t2_busy", {31'd0, busy}, 1);
    csum_m = 0;
    send_byte(8'd0);
    for (int i = 0; i < 256; i++) send_data(i, 8'(i));
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(csum_m);
`endif
    check("t2_cpu_run", {31'd0, cpu_run}, 1);
    check("t2_len", {23'd0, loaded_len}, 256);
    in_valid = 1;
    repeat (3) tick();
    in_valid = 0;
    check_log("t2_wr");
    gap = 3;
    for (int r = 0; r < 3; r++) begin
      rand_data(4);
      do_load(4);
      check("t3_cpu_run", {31'd0, cpu_run}, 1);
      check("t3_len", {23'd0, loaded_len}, 4);
      check_log("t3_wr");
      cpu_pc = 8'($urandom);
      #1 check("t3_addr_mux", {24'd0, im_addr}, {24'd0, cpu_pc});
      check("t3_data_zero", {24'd0, im_data}, 0);
      tick();
    end
    gap = 0;
    rand_data(3);
    pulse_start();
    csum_m = 0;
    send_byte(8'd3);
    send_data(0, d[0]);
    start = 1;
    tick();
    start = 0;
    check("t4_busy_ignored", {31'd0, busy}, 1);
    send_data(1, d[1]);
    send_data(2, d[2]);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(csum_m);
`endif
    check("t4_cpu_run", {31'd0, cpu_run}, 1);
    check("t4_len", {23'd0, loaded_len}, 3);
    rand_data(1);
    do_load(1);
    check("t4b_len", {23'd0, loaded_len}, 1);
    check("t4b_keep1", {24'd0, mem[1]}, {24'd0, exp_mem[1]});
    check_log("t4_wr");
    rand_data(5);
    pulse_start();
    csum_m = 0;
    send_byte(8'd5);
    send_data(0, d[0]);
    send_data(1, d[1]);
    #2 rst = 1;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_cpu_run", {31'd0, cpu_run}, 0);
    check("t5_ready", {31'd0, in_ready}, 0);
    check("t5_len", {23'd0, loaded_len}, 0);
    tick();
    rst = 0;
    check_log("t5_partial");
    rand_data(5);
    do_load(5);
    check("t5_cpu_run2", {31'd0, cpu_run}, 1);
    check("t5_len2", {23'd0, loaded_len}, 5);
    check_log("t5_wr");
`ifdef IM_LOADER_CHECKSUM_EN
    d = '{8'd10, 8'd20};
    do_load(2);
    check("ck_good_run", {31'd0, cpu_run}, 1);
    check("ck_good_err", {31'd0, err}, 0);
    pulse_start();
    csum_m = 0;
    send_byte(8'd2);
    send_data(0, 8'd10);
    send_data(1, 8'd20);
    send_byte(8'd31);
    check("ck_bad_err", {31'd0, err}, 1);
    check("ck_bad_run", {31'd0, cpu_run}, 0);
    check("ck_bad_busy", {31'd0, busy}, 0);
    check("ck_bad_len", {23'd0, loaded_len}, 2);
    pulse_start();
    check("ck_err_clr", {31'd0, err}, 0);
    send_byte(8'd1);
    send_data(0, 8'd7);
    send_byte(8'd7);
    check_log("ck_wr");
`endif
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check("mem_image", bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
